// File: rtl/nway_cache_control_pkg.sv
// Shared types and defaults for the N-way write-back cache controller.
package nway_cache_control_pkg;

    localparam int DEFAULT_WAYS = 4;
    localparam int DEFAULT_SETS = 8;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] cache_line;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        RESPOND
    } cache_ctrl_state_t;

endpackage

// File: rtl/nway_cache_control_plru_tree.sv
// Per-set tree pseudo-LRU: heap-ordered node bits (node n has children 2n+1 and 2n+2).
// A node bit of 0 steers the victim walk to the lower half of its subtree.
module plru_tree
    import nway_cache_control_pkg::*;
#(
    parameter int WAYS = DEFAULT_WAYS,
    parameter int SETS = DEFAULT_SETS,
    localparam int INDEX_W = $clog2(SETS),
    localparam int WAY_W   = $clog2(WAYS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] set_idx,
    input  logic               touch_en,
    input  logic [WAY_W-1:0]   touch_way,
    output logic [WAY_W-1:0]   victim_way
);

    logic [WAYS-2:0] tree [SETS];
    logic [WAYS-2:0] row;
    logic [WAYS-2:0] row_next;

    assign row = tree[set_idx];

    // Walk from the root following node bits; each level yields one victim bit, MSB first.
    always_comb begin : victim_walk
        logic [WAY_W-1:0] node;
        victim_way = '0;
        node       = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            victim_way[WAY_W-1-lvl] = row[node];
            node = WAY_W'(2 * node + 1 + row[node]);
        end
    end

    // Point every node on the path to touch_way away from it.
    always_comb begin : touch_path
        logic [WAY_W-1:0] node;
        logic             dir;
        row_next = row;
        node     = '0;
        dir      = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir            = touch_way[WAY_W-1-lvl];
            row_next[node] = ~dir;
            node           = WAY_W'(2 * node + 1 + dir);
        end
    end

    // Tree storage; the touched row is written back on the clock after the touch cycle.
    // NOTE: this array is a handful of flops, not a RAM, so it is cleared by the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                tree[s] <= '0;
            end
        end else if (touch_en) begin
            tree[set_idx] <= row_next;
        end
    end

endmodule

// File: rtl/nway_cache_control.sv
// N-way set-associative write-back cache controller: hit handling, victim
// writeback, line fill and array strobe generation for the datapath.
module nway_cache_control
    import nway_cache_control_pkg::*;
#(
    parameter int WAYS = DEFAULT_WAYS,
    parameter int SETS = DEFAULT_SETS,
    localparam int INDEX_W = $clog2(SETS),
    localparam int WAY_W   = $clog2(WAYS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [1:0]         mem_byte_enable,
    input  logic [INDEX_W-1:0] set_idx,
    input  logic [WAYS-1:0]    hit_way,
    input  logic [WAYS-1:0]    valid_way,
    input  logic [WAYS-1:0]    dirty_way,
    input  logic               pmem_resp,
    output logic               mem_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic               pmemmux_sel,
    output logic               rwmux_sel,
    output logic               stbwritemux_sel,
    output logic [WAY_W-1:0]   way_sel,
    output logic [WAYS-1:0]    data_write,
    output logic [WAYS-1:0]    tag_write,
    output logic [WAYS-1:0]    valid_write,
    output logic [WAYS-1:0]    dirty_write,
    output logic               dirty_in
);

    cache_ctrl_state_t state, state_next;

    logic [WAY_W-1:0] victim_q;
    logic [WAY_W-1:0] plru_victim;
    logic [WAY_W-1:0] hit_idx;
    logic [WAY_W-1:0] free_idx;
    logic [WAY_W-1:0] victim_sel;
    logic [WAY_W-1:0] touch_way;
    logic             any_free;
    logic             touch_en;
    logic             latch_victim;

    logic req, hit, wr_data, single_byte, victim_dirty;

    assign req          = mem_read | mem_write;
    assign hit          = |hit_way;
    assign wr_data      = mem_write && (mem_byte_enable != 2'b00);
    assign single_byte  = (mem_byte_enable == 2'b01) || (mem_byte_enable == 2'b10);
    assign victim_sel   = any_free ? free_idx : plru_victim;
    assign victim_dirty = valid_way[victim_sel] & dirty_way[victim_sel];

    function automatic logic [WAYS-1:0] onehot(input logic [WAY_W-1:0] w);
        onehot    = '0;
        onehot[w] = 1'b1;
    endfunction

    // Lowest hitting way and lowest invalid way (scan downward so the lowest index wins).
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        any_free = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_way[i]) hit_idx = WAY_W'(i);
            if (!valid_way[i]) begin
                free_idx = WAY_W'(i);
                any_free = 1'b1;
            end
        end
    end

    plru_tree #(.WAYS(WAYS), .SETS(SETS)) u_plru (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_idx    (set_idx),
        .touch_en   (touch_en),
        .touch_way  (touch_way),
        .victim_way (plru_victim)
    );

    // State register and victim latch.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            victim_q <= '0;
        end else begin
            state <= state_next;
            if (latch_victim) victim_q <= victim_sel;
        end
    end

    // Next-state and Mealy outputs; everything is forced low while reset is asserted.
    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_next      = state;
        mem_resp        = 1'b0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        pmemmux_sel     = 1'b0;
        rwmux_sel       = 1'b0;
        stbwritemux_sel = 1'b0;
        way_sel         = '0;
        data_write      = '0;
        tag_write       = '0;
        valid_write     = '0;
        dirty_write     = '0;
        dirty_in        = 1'b0;
        touch_en        = 1'b0;
        touch_way       = '0;
        latch_victim    = 1'b0;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    if (req && hit) begin
                        mem_resp  = 1'b1;
                        way_sel   = hit_idx;
                        touch_en  = 1'b1;
                        touch_way = hit_idx;
                        if (wr_data) begin
                            rwmux_sel       = 1'b1;
                            stbwritemux_sel = single_byte;
                            data_write      = onehot(hit_idx);
                            dirty_write     = onehot(hit_idx);
                            dirty_in        = 1'b1;
                        end
                    end else if (req) begin
                        latch_victim = 1'b1;
                        state_next   = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    pmem_write  = 1'b1;
                    pmemmux_sel = 1'b1;
                    way_sel     = victim_q;
                    if (pmem_resp) state_next = ALLOCATE;
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    way_sel   = victim_q;
                    if (pmem_resp) begin
                        data_write  = onehot(victim_q);
                        tag_write   = onehot(victim_q);
                        valid_write = onehot(victim_q);
                        dirty_write = onehot(victim_q);
                        state_next  = RESPOND;
                    end
                end
                RESPOND: begin
                    mem_resp   = 1'b1;
                    way_sel    = victim_q;
                    touch_en   = 1'b1;
                    touch_way  = victim_q;
                    state_next = IDLE;
                    if (wr_data) begin
                        rwmux_sel       = 1'b1;
                        stbwritemux_sel = single_byte;
                        data_write      = onehot(victim_q);
                        dirty_write     = onehot(victim_q);
                        dirty_in        = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nway_cache_control.sv
// Directed bench for nway_cache_control (WAYS=4, SETS=8) with hand-computed expectations.
module tb_nway_cache_control;

    logic       clk;
    logic       rst_n;
    logic       mem_read, mem_write;
    logic [1:0] mem_byte_enable;
    logic [2:0] set_idx;
    logic [3:0] hit_way, valid_way, dirty_way;
    logic       pmem_resp;
    logic       mem_resp, pmem_read, pmem_write, pmemmux_sel, rwmux_sel, stbwritemux_sel;
    logic [1:0] way_sel;
    logic [3:0] data_write, tag_write, valid_write, dirty_write;
    logic       dirty_in;

    int vectors    = 0;
    int miscompares = 0;

    nway_cache_control #(.WAYS(4), .SETS(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .set_idx         (set_idx),
        .hit_way         (hit_way),
        .valid_way       (valid_way),
        .dirty_way       (dirty_way),
        .pmem_resp       (pmem_resp),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmemmux_sel     (pmemmux_sel),
        .rwmux_sel       (rwmux_sel),
        .stbwritemux_sel (stbwritemux_sel),
        .way_sel         (way_sel),
        .data_write      (data_write),
        .tag_write       (tag_write),
        .valid_write     (valid_write),
        .dirty_write     (dirty_write),
        .dirty_in        (dirty_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
        set_idx = '0; hit_way = '0; valid_way = '0; dirty_way = '0; pmem_resp = 1'b0;
        #1;
        check("rst_mem_resp", mem_resp, 0);
        check("rst_pmem", {pmem_read, pmem_write, pmemmux_sel}, 0);
        check("rst_strobes", {data_write, tag_write, valid_write, dirty_write}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: cold read miss in set 3 fills way 0
        set_idx = 3'd3; valid_way = 4'b0000; hit_way = 4'b0000; dirty_way = 4'b0000; mem_read = 1'b1;
        #1;
        check("t1_idle_no_resp", {mem_resp, pmem_read}, 0);
        tick();
        check("t1_alloc_pmem_read", pmem_read, 1);
        check("t1_alloc_way_sel", way_sel, 0);
        check("t1_alloc_no_strobe", data_write, 0);
        pmem_resp = 1'b1; #1;
        check("t1_fill_strobes", {data_write, tag_write, valid_write, dirty_write}, 16'h1111);
        check("t1_fill_dirty_in", dirty_in, 0);
        tick();
        pmem_resp = 1'b0; #1;
        check("t1_respond", {mem_resp, pmem_read, way_sel}, 4'b1000);
        mem_read = 1'b0;
        tick();

        // 2: read hit way 2 in set 5, then clean miss in set 5 picks way 0
        set_idx = 3'd5; valid_way = 4'b1111; hit_way = 4'b0100; mem_read = 1'b1; #1;
        check("t2_hit_resp", mem_resp, 1);
        check("t2_hit_way_sel", way_sel, 2);
        check("t2_hit_no_strobe", {data_write, dirty_write}, 0);
        tick();
        hit_way = 4'b0000; #1;
        check("t2_miss_no_resp", mem_resp, 0);
        tick();
        check("t2_alloc", {pmem_read, pmem_write, way_sel}, 4'b1000);
        pmem_resp = 1'b1; tick(); pmem_resp = 1'b0; #1;
        check("t2_respond", mem_resp, 1);
        mem_read = 1'b0; tick();

        // 3: touch ways 0,2,1 in set 0, then a miss picks way 3
        set_idx = 3'd0; valid_way = 4'b1111; mem_read = 1'b1;
        hit_way = 4'b0001; #1; check("t3_hit0", {mem_resp, way_sel}, 3'b100); tick();
        hit_way = 4'b0100; #1; check("t3_hit2", {mem_resp, way_sel}, 3'b110); tick();
        hit_way = 4'b0010; #1; check("t3_hit1", {mem_resp, way_sel}, 3'b101); tick();
        hit_way = 4'b0000; tick();
        check("t3_victim_way3", {pmem_read, way_sel}, 3'b111);
        pmem_resp = 1'b1; #1;
        check("t3_fill_way3", tag_write, 4'b1000);
        tick(); pmem_resp = 1'b0;
        mem_read = 1'b0; tick();

        // invalid-first: way 1 invalid (and marked dirty) is chosen without a writeback
        valid_way = 4'b1101; dirty_way = 4'b0010; mem_read = 1'b1; #1;
        tick();
        check("inv_first_alloc", {pmem_read, pmem_write, way_sel}, 4'b1001);
        pmem_resp = 1'b1; tick(); pmem_resp = 1'b0;
        mem_read = 1'b0; dirty_way = 4'b0000; tick();

        // 4: dirty write miss in set 1, byte enable 01
        set_idx = 3'd1; valid_way = 4'b1111; dirty_way = 4'b0001; hit_way = 4'b0000;
        mem_write = 1'b1; mem_byte_enable = 2'b01; #1;
        check("t4_idle_no_strobe", {mem_resp, data_write}, 0);
        tick();
        check("t4_wb_cycle1", {pmem_write, pmemmux_sel, pmem_read, way_sel}, 5'b11000);
        tick();
        check("t4_wb_cycle2", pmem_write, 1);
        tick();
        pmem_resp = 1'b1; #1;
        check("t4_wb_cycle3", {pmem_write, mem_resp}, 2'b10);
        tick();
        pmem_resp = 1'b0; #1;
        check("t4_alloc", {pmem_read, pmem_write, pmemmux_sel, way_sel}, 5'b10000);
        pmem_resp = 1'b1; #1;
        check("t4_fill_strobes", {data_write, tag_write, valid_write, dirty_write, dirty_in}, 17'b0001_0001_0001_0001_0);
        tick();
        pmem_resp = 1'b0; #1;
        check("t4_resp_data_write", data_write, 4'b0001);
        check("t4_resp_dirty", {dirty_write, dirty_in}, 5'b0001_1);
        check("t4_resp_muxes", {mem_resp, rwmux_sel, stbwritemux_sel}, 3'b111);
        check("t4_resp_no_tag", {tag_write, valid_write}, 0);
        mem_write = 1'b0; mem_byte_enable = 2'b00; dirty_way = 4'b0000; tick();

        // full-word write hit way 3 in set 2
        set_idx = 3'd2; hit_way = 4'b1000; mem_write = 1'b1; mem_byte_enable = 2'b11; #1;
        check("wr_hit_full", {mem_resp, rwmux_sel, stbwritemux_sel, dirty_in}, 4'b1101);
        check("wr_hit_full_strobe", {data_write, dirty_write, tag_write}, 12'b1000_1000_0000);
        tick();
        // read+write together behaves as a write; byte enable 10 is a single-byte merge
        mem_read = 1'b1; hit_way = 4'b0010; mem_byte_enable = 2'b10; #1;
        check("rw_both_as_write", {data_write, stbwritemux_sel, way_sel}, 7'b0010_1_01);
        tick();
        // multiple hit bits: lowest wins
        mem_write = 1'b0; hit_way = 4'b0110; #1;
        check("multi_hit_lowest", {mem_resp, way_sel, data_write}, 7'b1_01_0000);
        tick();

        // 5: write hit with byte enable 00 responds with no strobes
        mem_read = 1'b0; mem_write = 1'b1; mem_byte_enable = 2'b00; hit_way = 4'b0010; #1;
        check("t5_resp", mem_resp, 1);
        check("t5_no_strobes", {data_write, tag_write, valid_write, dirty_write, rwmux_sel, dirty_in}, 0);
        mem_write = 1'b0; hit_way = 4'b0000; tick();

        // 6: reset during ALLOCATE; afterwards IDLE with cleared PLRU (set 0 would otherwise pick way 2)
        set_idx = 3'd7; valid_way = 4'b1111; mem_read = 1'b1; #1;
        tick();
        check("t6_alloc_before_rst", pmem_read, 1);
        rst_n = 1'b0; #1;
        check("t6_async_drop", {pmem_read, mem_resp, way_sel}, 0);
        mem_read = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1; #1;
        check("t6_idle_after_rst", {pmem_read, pmem_write, mem_resp}, 0);
        set_idx = 3'd0; mem_read = 1'b1; #1;
        tick();
        check("t6_plru_cleared", {pmem_read, way_sel}, 3'b100);
        pmem_resp = 1'b1; tick(); pmem_resp = 1'b0; #1;
        check("t6_respond", mem_resp, 1);
        mem_read = 1'b0; tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
